// File: rtl/graph_conv_event_scheduler.sv
// Event sequencer for graph_conv: loads neighbours into the FIFO, starts the core and waits for done.
// Tracks dropped neighbours, WAIT timeouts and completed events.
module graph_conv_event_scheduler #(
  parameter int FIFO_WIDTH     = 72,
  parameter int MAX_DEGREE     = 16,
  parameter int CNT_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic [FIFO_WIDTH-1:0] ev_data,
  input  logic [CNT_WIDTH-1:0]  ev_nbr_cnt,
  input  logic                  nbr_valid,
  output logic                  nbr_ready,
  input  logic [FIFO_WIDTH-1:0] nbr_data,
  output logic                  fifo_wr_en,
  output logic [FIFO_WIDTH-1:0] fifo_din,
  input  logic                  fifo_full,
  output logic                  module_start,
  output logic [FIFO_WIDTH-1:0] new_event,
  input  logic                  module_done,
  output logic                  busy,
  output logic                  err_overflow,
  output logic                  err_timeout,
  output logic [STAT_WIDTH-1:0] ev_processed
);

  localparam int FW = $clog2(MAX_DEGREE + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH:0] MAXC = (CNT_WIDTH + 1)'(MAX_DEGREE);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT
  } state_e;

  state_e                  state_q;
  logic [CNT_WIDTH-1:0]    rem_q;
  logic [FW-1:0]           fwd_q;
  logic [TW-1:0]           tmr_q;
  logic                    ev_ready_q;
  logic                    ovf_q;
  logic                    to_q;
  logic [STAT_WIDTH-1:0]   proc_q;
  logic [FIFO_WIDTH-1:0]   new_ev_q;

  logic at_max;
  logic hs;
  logic tmo;
  logic ev_acc;

  assign at_max = (fwd_q == FW'(MAX_DEGREE));
  // Once MAX_DEGREE words are in, excess words are drained even if full.
  assign nbr_ready = (state_q == S_LOAD) && (!fifo_full || at_max);
  assign hs = nbr_valid && nbr_ready;
  assign fifo_wr_en = hs && !at_max;
  assign fifo_din = nbr_data;
  assign tmo = (TIMEOUT_CYCLES != 0) && (tmr_q == TLAST);
  assign ev_acc = ev_valid && ev_ready_q;

  assign ev_ready = ev_ready_q;
  assign module_start = (state_q == S_START);
  assign busy = (state_q != S_IDLE);
  assign new_event = new_ev_q;
  assign err_overflow = ovf_q;
  assign err_timeout = to_q;
  assign ev_processed = proc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      fwd_q      <= '0;
      tmr_q      <= '0;
      ev_ready_q <= 1'b0;
      ovf_q      <= 1'b0;
      to_q       <= 1'b0;
      proc_q     <= '0;
      new_ev_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ev_acc) begin
            new_ev_q   <= ev_data;
            rem_q      <= ev_nbr_cnt;
            fwd_q      <= '0;
            ev_ready_q <= 1'b0;
            if ({1'b0, ev_nbr_cnt} > MAXC) ovf_q <= 1'b1;
            state_q <= (ev_nbr_cnt != '0) ? S_LOAD : S_START;
          end else begin
            ev_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (hs) begin
            rem_q <= rem_q - CNT_WIDTH'(1);
            if (!at_max) fwd_q <= fwd_q + FW'(1);
            if (rem_q == CNT_WIDTH'(1)) state_q <= S_START;
          end
        end
        S_START: begin
          tmr_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          tmr_q <= tmr_q + TW'(1);
          if (module_done) begin
            proc_q     <= proc_q + STAT_WIDTH'(1);
            ev_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end else if (tmo) begin
            to_q       <= 1'b1;
            ev_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_graph_conv_event_scheduler.sv
// Bench for graph_conv_event_scheduler: directed table, corner sequences and
// randomized events against an event-level reference model.
module tb_graph_conv_event_scheduler;

  localparam int W    = 72;
  localparam int MAXD = 16;
  localparam int CW   = 5;
  localparam int TO   = 32;
  localparam int SW   = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_ready;
  logic [W-1:0]  ev_data = '0;
  logic [CW-1:0] ev_nbr_cnt = '0;
  logic          nbr_valid = 1'b0;
  logic          nbr_ready;
  logic [W-1:0]  nbr_data = '0;
  logic          fifo_wr_en;
  logic [W-1:0]  fifo_din;
  logic          fifo_full = 1'b0;
  logic          module_start;
  logic [W-1:0]  new_event;
  logic          module_done = 1'b0;
  logic          busy;
  logic          err_overflow;
  logic          err_timeout;
  logic [SW-1:0] ev_processed;

  always #5 clk = ~clk;

  graph_conv_event_scheduler #(
    .FIFO_WIDTH(W),
    .MAX_DEGREE(MAXD),
    .CNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TO),
    .STAT_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_data(ev_data),
    .ev_nbr_cnt(ev_nbr_cnt),
    .nbr_valid(nbr_valid),
    .nbr_ready(nbr_ready),
    .nbr_data(nbr_data),
    .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din),
    .fifo_full(fifo_full),
    .module_start(module_start),
    .new_event(new_event),
    .module_done(module_done),
    .busy(busy),
    .err_overflow(err_overflow),
    .err_timeout(err_timeout),
    .ev_processed(ev_processed)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int g, input int e);
    total++;
    if (g != e) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, g, e);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] g,
                      input logic [W-1:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, g, e);
    end
  endtask

  // Observed traffic, sampled mid-cycle.
  logic [W-1:0] got_q[$];
  int hs_n = 0;
  int st_n = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (fifo_wr_en) got_q.push_back(fifo_din);
      if (nbr_valid && nbr_ready) hs_n <= hs_n + 1;
      if (module_start) st_n <= st_n + 1;
    end
  end

  // Reference model state.
  logic [W-1:0] exp_q[$];
  bit m_ovf = 0;
  bit m_to = 0;
  int m_proc = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word(input int tag);
    logic [W-1:0] w;
    w = {8'(tag), 32'($urandom), 32'($urandom)};
    return w;
  endfunction

  // One full event: cnt neighbours, fifo_full high for LOAD cycles
  // [fa, fa+fl), done after dly WAIT cycles (dly < 0: never).
  task automatic run_event(input int cnt, input int dly,
                           input int fa, input int fl);
    logic [W-1:0] d;
    logic [W-1:0] w;
    int i, k, n, hs0, st0;
    bit rdy;
    d = rnd_word(cnt);
    got_q.delete();
    exp_q.delete();
    hs0 = hs_n;
    st0 = st_n;
    n = 0;
    while (!ev_ready && n < 50) begin
      tick;
      n++;
    end
    chk("ev_ready_idle", int'(ev_ready), 1);
    ev_valid = 1'b1;
    ev_data = d;
    ev_nbr_cnt = CW'(cnt);
    tick;
    ev_valid = 1'b0;
    if (cnt > MAXD) m_ovf = 1;
    i = 0;
    k = 0;
    n = 0;
    w = rnd_word(0);
    while (i < cnt && n < 300) begin
      nbr_valid = 1'b1;
      nbr_data = w;
      fifo_full = (k >= fa && k < fa + fl);
      #1;
      rdy = nbr_ready;
      chk("nbr_ready", int'(rdy), int'(!fifo_full || i >= MAXD));
      tick;
      if (rdy) begin
        if (i < MAXD) exp_q.push_back(w);
        i++;
        w = rnd_word(i);
      end
      k++;
      n++;
    end
    if (n >= 300) chk("load_bound", i, cnt);
    nbr_valid = 1'b0;
    fifo_full = 1'b0;
    chk("start_latency", int'(module_start), 1);
    chkw("new_event_start", new_event, d);
    tick;
    if (dly >= 0) begin
      repeat (dly) tick;
      chkw("new_event_wait", new_event, d);
      module_done = 1'b1;
      tick;
      module_done = 1'b0;
      m_proc = (m_proc + 1) % (1 << SW);
      chk("done_ev_ready", int'(ev_ready), 1);
      chk("done_busy", int'(busy), 0);
    end else begin
      n = 0;
      while (busy && n < 100) begin
        tick;
        n++;
      end
      chk("timeout_cycles", n, TO);
      m_to = 1;
    end
    chk("fifo_writes", got_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
      chkw("fifo_data", got_q[j], exp_q[j]);
    chk("nbr_handshakes", hs_n - hs0, cnt);
    chk("start_pulses", st_n - st0, 1);
    chk("err_overflow", int'(err_overflow), int'(m_ovf));
    chk("err_timeout", int'(err_timeout), int'(m_to));
    chk("ev_processed", int'(ev_processed), m_proc);
  endtask

  typedef struct {
    int cnt;
    int dly;
    int fa;
    int fl;
    int exp_wr;
    int exp_ovf;
  } vec_t;

  vec_t vt[6];

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ev_ready"}, int'(ev_ready), 0);
    chk({nm, "_nbr_ready"}, int'(nbr_ready), 0);
    chk({nm, "_fifo_wr_en"}, int'(fifo_wr_en), 0);
    chk({nm, "_module_start"}, int'(module_start), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_err_overflow"}, int'(err_overflow), 0);
    chk({nm, "_err_timeout"}, int'(err_timeout), 0);
    chk({nm, "_ev_processed"}, int'(ev_processed), 0);
    chkw({nm, "_new_event"}, new_event, '0);
  endtask

  initial begin
    vt[0] = '{3, 5, 99, 0, 3, 0};
    vt[1] = '{0, 10, 99, 0, 0, 0};
    vt[2] = '{16, 31, 0, 3, 16, 0};
    vt[3] = '{20, 2, 99, 0, 16, 1};
    vt[4] = '{8, 3, 2, 5, 8, 1};
    vt[5] = '{1, 0, 99, 0, 1, 1};

    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    tick;
    chk("post_reset_ready", int'(ev_ready), 1);

    for (int v = 0; v < 6; v++) begin
      run_event(vt[v].cnt, vt[v].dly, vt[v].fa, vt[v].fl);
      chk("tbl_writes", got_q.size(), vt[v].exp_wr);
      chk("tbl_overflow", int'(err_overflow), vt[v].exp_ovf);
    end

    run_event(2, -1, 99, 0);
    chk("timeout_flag", int'(err_timeout), 1);
    chk("timeout_proc", int'(ev_processed), 6);

    // Reset while the core is busy.
    while (!ev_ready) tick;
    ev_valid = 1'b1;
    ev_data = rnd_word(77);
    ev_nbr_cnt = '0;
    tick;
    ev_valid = 1'b0;
    repeat (4) tick;
    chk("wait_busy", int'(busy), 1);
    rstn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    m_ovf = 0;
    m_to = 0;
    m_proc = 0;
    tick;
    rstn = 1'b1;
    tick;

    for (int e = 0; e < 16; e++) begin
      run_event($urandom_range(0, 18), $urandom_range(0, 25),
                $urandom_range(0, 4), $urandom_range(0, 6));
      if (e == 14) chk("proc_15", int'(ev_processed), 15);
      if (e == 15) chk("proc_wrap", int'(ev_processed), 0);
    end

    for (int e = 0; e < 12; e++) begin
      run_event($urandom_range(0, 22),
                ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 25),
                $urandom_range(0, 6), $urandom_range(0, 8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck, want finish");
    $fatal(1);
  end

endmodule
